// File: rtl/bram_stream_reader_pkg.sv
// bram_pkg: shared types and parameter legality helpers for the BRAM
// stream reader.
//   rd_state_t     - reader FSM states (IDLE, FETCH, DRAIN)
//   LAT_COMB/REG   - the two supported BRAM port B read latencies
//   latency_legal  - true for a supported BRAM_LATENCY
//   depth_legal    - true for a power-of-two FIFO depth of at least 2
package bram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int LAT_COMB = 0;
    localparam int LAT_REG  = 1;

    function automatic bit latency_legal(input int lat);
        return (lat == LAT_COMB) || (lat == LAT_REG);
    endfunction

    function automatic bit depth_legal(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: command and output stream of the BRAM reader.
//   cmd_valid/cmd_ready  - command handshake
//   cmd_addr             - first word address
//   cmd_len_m1           - word count minus one
//   out_data/out_last    - stream payload, last marks the final word
//   out_valid/out_ready  - stream handshake
// master: the requester/consumer side. slave: the reader.
interface bram_stream_reader_if #(
    parameter int width_a   = 8,
    parameter int widthad_a = 10
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [widthad_a-1:0] cmd_addr;
    logic [widthad_a-1:0] cmd_len_m1;
    logic [width_a-1:0]   out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_len_m1, out_ready,
        input  cmd_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len_m1, out_ready,
        output cmd_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/bram_stream_reader_sync_fifo.sv
// sync_fifo: storage FIFO with a registered head stage.
//   clock, reset_n  - clock, async active-low reset
//   flush           - synchronous clear of storage and head
//   push, din       - write side (never pushed when full)
//   count           - words in storage, excluding the head register
//   mem_pop         - storage word moves into the head this cycle
//   dout/dout_valid - registered head, held stable until dout_ready
//   dout_ready      - consumer accepts the head
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
)(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    output logic [$clog2(DEPTH):0] count,
    output logic                   mem_pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Head refills whenever it is empty or being consumed; no bypass from
    // push, so a pushed word reaches the head one cycle later.
    assign mem_pop = (count != '0) && (!dout_valid || dout_ready);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (mem_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(mem_pop);
            if (mem_pop) begin
                dout       <= mem[rd_ptr];
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: sequential read engine on BRAM port B.
//   clock, reset_n - clock (also BRAM clock_b), async active-low reset
//   bus            - command in, {last,data} valid/ready stream out
//   abort          - cancel the command and flush buffered words
//   bram_address   - BRAM address_b
//   bram_wren      - BRAM wren_b, tied low
//   bram_q         - BRAM q_b, 0 or 1 cycle after the address
//   busy           - command active or words still buffered
module bram_stream_reader
    import bram_pkg::*;
#(
    parameter int width_a      = 8,
    parameter int widthad_a    = 10,
    parameter int BRAM_LATENCY = 0,
    parameter int FIFO_DEPTH   = 4
)(
    input  logic                  clock,
    input  logic                  reset_n,
    bram_stream_reader_if.slave   bus,
    input  logic                  abort,
    output logic [widthad_a-1:0]  bram_address,
    output logic                  bram_wren,
    input  logic [width_a-1:0]    bram_q,
    output logic                  busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (!latency_legal(BRAM_LATENCY) || !depth_legal(FIFO_DEPTH)) begin : g_bad_param
        $error("bram_stream_reader: BRAM_LATENCY must be 0/1, FIFO_DEPTH a power of two >= 2");
    end

    rd_state_t            state, state_nxt;
    logic [widthad_a-1:0] remaining;
    logic                 accept, credit, issue, issue_last;
    logic                 push, push_last, inflight;
    logic                 mem_pop, drain_done;
    logic [CW-1:0]        fifo_count;
    logic [width_a:0]     head;
    logic                 head_valid;

    assign bram_wren     = 1'b0;
    assign bus.cmd_ready = (state == IDLE) && !abort;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // A storage slot being vacated this cycle counts as free, which keeps
    // one word per cycle flowing at the minimum depth with latency 1.
    assign credit     = (int'(fifo_count) + int'(inflight)) < (FIFO_DEPTH + int'(mem_pop));
    assign issue      = (state == FETCH) && !abort && credit;
    assign issue_last = issue && (remaining == '0);

    // Everything delivered once nothing is in flight, storage is empty and
    // the head is empty or leaving now.
    assign drain_done = !inflight && (fifo_count == '0) && (!head_valid || bus.out_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)     state_nxt = FETCH;
                FETCH:   if (issue_last) state_nxt = DRAIN;
                DRAIN:   if (drain_done) state_nxt = IDLE;
                default:                 state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bram_address <= '0;
            remaining    <= '0;
        end else if (accept) begin
            bram_address <= bus.cmd_addr;
            remaining    <= bus.cmd_len_m1;
        end else if (issue) begin
            bram_address <= bram_address + 1'b1;
            remaining    <= remaining - 1'b1;
        end
    end

    if (BRAM_LATENCY == LAT_COMB) begin : g_lat0
        assign push      = issue;
        assign push_last = issue_last;
        assign inflight  = 1'b0;
    end else begin : g_lat1
        logic last_d;
        // issue already excludes abort, so an abort drops the pending capture
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                inflight <= 1'b0;
                last_d   <= 1'b0;
            end else begin
                inflight <= issue;
                last_d   <= issue_last;
            end
        end
        assign push      = inflight;
        assign push_last = last_d;
    end

    sync_fifo #(
        .WIDTH (width_a + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (abort),
        .push       (push),
        .din        ({push_last, bram_q}),
        .count      (fifo_count),
        .mem_pop    (mem_pop),
        .dout       (head),
        .dout_valid (head_valid),
        .dout_ready (bus.out_ready)
    );

    assign bus.out_valid = head_valid;
    assign bus.out_data  = head[width_a-1:0];
    assign bus.out_last  = head[width_a];

    assign busy = (state != IDLE) || (fifo_count != '0) || head_valid || inflight;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a latency-0 and a latency-1 instance run
// the same command/ready stimulus side by side, each against a BRAM model
// preloaded with mem[i] = i[7:0] and its own expected-word queue.
module tb_bram_stream_reader;
    localparam int W     = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int NW    = 1 << AW;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          abort      = 1'b0;
    logic          cmd_valid  = 1'b0;
    logic          out_ready  = 1'b0;
    logic [AW-1:0] cmd_addr   = '0;
    logic [AW-1:0] cmd_len_m1 = '0;

    logic [AW-1:0] baddr   [2];
    logic          bwren   [2];
    logic          busy    [2];
    logic          cmd_rdy [2];
    logic          ov      [2];
    logic          ol      [2];
    logic [W-1:0]  od      [2];
    logic [W-1:0]  bq0, bq1;
    logic [W-1:0]  mem [NW];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int e0      = 0;
    logic [W:0] sb [2][$];
    int nrx [2];
    int first_cyc [2];
    bit arm [2];
    int vrun [2];
    int vmax [2];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // BRAM models: combinational and registered port B
    assign bq0 = mem[baddr[0]];
    always @(posedge clock) bq1 <= mem[baddr[1]];

    bram_stream_reader_if #(.width_a(W), .widthad_a(AW)) bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].cmd_valid  = cmd_valid;
        assign bus[g].cmd_addr   = cmd_addr;
        assign bus[g].cmd_len_m1 = cmd_len_m1;
        assign bus[g].out_ready  = out_ready;
        assign cmd_rdy[g] = bus[g].cmd_ready;
        assign ov[g]      = bus[g].out_valid;
        assign ol[g]      = bus[g].out_last;
        assign od[g]      = bus[g].out_data;

        bram_stream_reader #(
            .width_a      (W),
            .widthad_a    (AW),
            .BRAM_LATENCY (g),
            .FIFO_DEPTH   (DEPTH)
        ) u_dut (
            .clock        (clock),
            .reset_n      (reset_n),
            .bus          (bus[g]),
            .abort        (abort),
            .bram_address (baddr[g]),
            .bram_wren    (bwren[g]),
            .bram_q       ((g == 0) ? bq0 : bq1),
            .busy         (busy[g])
        );

        logic       stall_q  = 1'b0;
        logic       last_pop = 1'b0;
        logic [W:0] word_q   = '0;

        always @(negedge clock) begin : mon
            logic [W:0] word, expw;
            word = {ol[g], od[g]};
            if (!reset_n) begin
                stall_q  = 1'b0;
                last_pop = 1'b0;
                vrun[g]  = 0;
            end else begin
                if (last_pop) begin
                    chk($sformatf("cmd_ready_after_last%0d", g), cmd_rdy[g], 1);
                    chk($sformatf("idle_after_last%0d", g), busy[g], 0);
                end
                if (stall_q && ov[g]) chk($sformatf("stable%0d", g), word, word_q);
                if (arm[g] && ov[g]) begin
                    first_cyc[g] = cyc;
                    arm[g]       = 1'b0;
                end
                vrun[g] = ov[g] ? vrun[g] + 1 : 0;
                if (vrun[g] > vmax[g]) vmax[g] = vrun[g];
                last_pop = 1'b0;
                if (ov[g] && out_ready) begin
                    nrx[g]++;
                    if (sb[g].size() == 0) begin
                        chk($sformatf("unexpected_word%0d", g), ov[g], 0);
                    end else begin
                        expw = sb[g].pop_front();
                        chk($sformatf("word%0d", g), word, expw);
                        last_pop = ol[g];
                    end
                end
                stall_q = ov[g] && !out_ready;
                word_q  = word;
            end
        end
    end

    // Runs in the phase just after a rising edge; returns in the same phase.
    task automatic send_cmd(input logic [AW-1:0] a, input int len_m1);
        int t = 0;
        while (!(cmd_rdy[0] && cmd_rdy[1]) && t < 200) begin
            @(posedge clock); #1; t++;
        end
        chk("cmd_ready_wait", {cmd_rdy[0], cmd_rdy[1]}, 2'b11);
        for (int i = 0; i <= len_m1; i++) begin
            for (int g = 0; g < 2; g++)
                sb[g].push_back({i == len_m1, mem[(int'(a) + i) % NW]});
        end
        arm[0]     = 1'b1;
        arm[1]     = 1'b1;
        cmd_addr   = a;
        cmd_len_m1 = AW'(len_m1);
        cmd_valid  = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        e0        = cyc;
        @(negedge clock);
        chk("addr_first0", baddr[0], a);
        chk("addr_first1", baddr[1], a);
        @(posedge clock); #1;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((busy[0] || busy[1] || sb[0].size() != 0 || sb[1].size() != 0) && t < budget) begin
            @(posedge clock); #1; t++;
        end
        chk("idle_timeout", {busy[0], busy[1]}, 0);
        chk("sb_left0", sb[0].size(), 0);
        chk("sb_left1", sb[1].size(), 0);
        @(posedge clock); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_cmd_ready%0d", tag, g), cmd_rdy[g], 1);
            chk($sformatf("%s_addr%0d", tag, g), baddr[g], 0);
            chk($sformatf("%s_wren%0d", tag, g), bwren[g], 0);
            chk($sformatf("%s_data%0d", tag, g), od[g], 0);
            chk($sformatf("%s_valid%0d", tag, g), ov[g], 0);
            chk($sformatf("%s_last%0d", tag, g), ol[g], 0);
            chk($sformatf("%s_busy%0d", tag, g), busy[g], 0);
        end
    endtask

    initial begin
        logic [AW-1:0] a_hold [2];
        int t;
        for (int i = 0; i < NW; i++) mem[i] = W'(i);

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_vals("rst");
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // single word, first-valid latency
        out_ready = 1'b1;
        nrx[0] = 0; nrx[1] = 0;
        send_cmd(10'h010, 0);
        wait_idle(100);
        chk("first_valid_lat0", first_cyc[0] - e0, 2);
        chk("first_valid_lat1", first_cyc[1] - e0, 3);
        chk("rx_single0", nrx[0], 1);
        chk("rx_single1", nrx[1], 1);

        // address wrap
        nrx[0] = 0; nrx[1] = 0;
        send_cmd(10'h3FE, 3);
        wait_idle(100);
        chk("rx_wrap0", nrx[0], 4);
        chk("rx_wrap1", nrx[1], 4);

        // backpressure: stall fully, then 3-low/1-high
        nrx[0] = 0; nrx[1] = 0;
        out_ready = 1'b0;
        send_cmd(10'h080, 15);
        repeat (12) @(posedge clock);
        #1;
        a_hold[0] = baddr[0];
        a_hold[1] = baddr[1];
        repeat (4) @(posedge clock);
        #1;
        chk("addr_stall0", baddr[0], a_hold[0]);
        chk("addr_stall1", baddr[1], a_hold[1]);
        chk("no_pop_stalled0", nrx[0], 0);
        chk("no_pop_stalled1", nrx[1], 0);
        for (int i = 0; i < 400 && (busy[0] || busy[1]); i++) begin
            out_ready = (i % 4 == 3);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        wait_idle(50);
        chk("rx_bp0", nrx[0], 16);
        chk("rx_bp1", nrx[1], 16);

        // throughput
        nrx[0] = 0; nrx[1] = 0;
        vmax[0] = 0; vmax[1] = 0;
        send_cmd(10'h100, 63);
        wait_idle(200);
        chk("run_len0", vmax[0], 64);
        chk("run_len1", vmax[1], 64);
        chk("rx_tput0", nrx[0], 64);
        chk("rx_tput1", nrx[1], 64);

        // abort with the FIFO partly full
        nrx[0] = 0; nrx[1] = 0;
        send_cmd(10'h200, 31);
        t = 0;
        while (nrx[0] < 5 && t < 100) begin
            @(posedge clock); #1; t++;
        end
        chk("abort_setup", nrx[0] >= 5, 1);
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("busy_before_abort", {busy[0], busy[1]}, 2'b11);
        abort = 1'b1;
        sb[0].delete();
        sb[1].delete();
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("abort_valid%0d", g), ov[g], 0);
            chk($sformatf("abort_cmd_ready%0d", g), cmd_rdy[g], 1);
            chk($sformatf("abort_busy%0d", g), busy[g], 0);
        end
        repeat (3) @(negedge clock);
        chk("abort_quiet0", ov[0], 0);
        chk("abort_quiet1", ov[1], 0);
        @(posedge clock); #1;
        out_ready = 1'b1;
        nrx[0] = 0; nrx[1] = 0;
        send_cmd(10'h055, 7);
        wait_idle(100);
        chk("rx_post_abort0", nrx[0], 8);
        chk("rx_post_abort1", nrx[1], 8);

        // async reset mid-FETCH, off a clock edge
        send_cmd(10'h300, 31);
        repeat (4) @(posedge clock);
        #3;
        chk("busy_before_reset", {busy[0], busy[1]}, 2'b11);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        sb[0].delete();
        sb[1].delete();
        @(posedge clock); #3;
        reset_n = 1'b1;
        @(posedge clock); #1;
        nrx[0] = 0; nrx[1] = 0;
        send_cmd(10'h0F0, 2);
        wait_idle(100);
        chk("rx_post_reset0", nrx[0], 3);
        chk("rx_post_reset1", nrx[1], 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Sequential read engine that sits directly downstream of the dual-port `bram` block's port B. It accepts a (start address, length) command, issues consecutive read addresses to the BRAM, and absorbs the BRAM's read latency (0 or 1 cycle, matching that block's `BRAM_LATENCY`). Words are presented on a valid/ready stream with a last flag through a small FIFO. Typical consumers are the video scanline shifter and the disk/sound DMA paths.

## Interface
Parameters:
- `width_a`, 8: data word width; must equal the BRAM `width_a`.
- `widthad_a`, 10: BRAM address width.
- `BRAM_LATENCY`, 0: port B read latency of the attached BRAM. 0 means combinational; 1 means registered. Any other value is illegal.
- `FIFO_DEPTH`, 4: output buffer entries; a power of two, at least 2.

Ports:
- `clock`, in, 1: single clock. Also drives BRAM `clock_b`.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: high only in IDLE.
- `cmd_addr`, in, `widthad_a`: first word address.
- `cmd_len_m1`, in, `widthad_a`: word count minus 1 (1..2^widthad_a words).
- `abort`, in, 1: cancel the current command; flush the FIFO.
- `bram_address`, out, `widthad_a`: drives BRAM `address_b`.
- `bram_wren`, out, 1: drives BRAM `wren_b`; constant 0.
- `bram_q`, in, `width_a`: from BRAM `q_b`.
- `out_data`, out, `width_a`: stream data.
- `out_valid`, out, 1: stream valid.
- `out_ready`, in, 1: stream ready.
- `out_last`, out, 1: marks the final word of a command.
- `busy`, out, 1: high when not IDLE or the FIFO is non-empty.

## Operation
- FSM states are IDLE, FETCH and DRAIN.
- IDLE:
  - A `cmd_valid && cmd_ready` handshake latches the address and remaining count (`cmd_len_m1`).
  - The FSM then moves to FETCH.
- FETCH:
  - The engine issues a read when `fifo_count + inflight < FIFO_DEPTH`. `inflight` is 0 or 1, and is always 0 for latency 0.
  - On each issue, `bram_address` advances by 1 modulo 2^widthad_a. The address wraps from all-ones to 0 with no error.
  - The remaining count decrements on each issue.
  - On the issue with remaining == 0, the FSM moves to DRAIN. That word carries `out_last = 1`.
- DRAIN: when the FIFO is empty and `inflight == 0`, the FSM moves to IDLE.
- Capture:
  - With latency 0, `bram_q` is pushed in the same cycle its address is presented.
  - With latency 1, `bram_q` is pushed the cycle after issue, with the `last` tag delayed alongside it.
- The FIFO entry is `{last, data}`. Push and pop in the same cycle are legal when the FIFO is full or empty-with-bypass-disabled. The FIFO never overflows because of the credit check.
- `abort` has priority over all other events:
  - Next state is IDLE.
  - The FIFO is cleared.
  - The in-flight capture is discarded.
  - `out_valid` is 0 the following cycle.
  - `abort` in IDLE with an empty FIFO has no effect.
- `bram_address` holds its last value when not issuing. No reads are issued in IDLE or DRAIN.
- A command arriving while `cmd_ready = 0` is not accepted. The requester holds it.

## Timing
- Reset values:
  - State is IDLE.
  - `cmd_ready` = 1.
  - `bram_address` = 0.
  - `bram_wren` = 0.
  - `out_data` = 0.
  - `out_valid` = 0.
  - `out_last` = 0.
  - `busy` = 0.
  - FIFO empty; `inflight` = 0.
- Let command acceptance be edge E0.
  - `bram_address = cmd_addr` is presented in the cycle after E0.
  - The first `out_valid` rises after E0+2 edges for latency 0, and after E0+3 edges for latency 1.
- Sustained throughput is 1 word/cycle with `out_ready` held high, for both latencies at `FIFO_DEPTH` >= 2.
- Stream rules:
  - `out_data` and `out_last` are registered FIFO head outputs.
  - They stay stable while `out_valid && !out_ready`.
- `cmd_ready` returns 1 the cycle after the last word is popped.
- Reset assertion mid-command forces the reset values immediately (asynchronously).

## Structure
- Package `bram_pkg`:
  - State enum `rd_state_t` (IDLE, FETCH, DRAIN).
  - `localparam` checks on legal `BRAM_LATENCY` values.
- Sub-module `sync_fifo`: parameterized width/depth, with count, registered head, and synchronous flush.
- The top level holds the FSM, address counter, remaining counter, and latency pipe (generate on `BRAM_LATENCY`).

## Test plan
- **Single word:** `cmd_addr=0x010`, `cmd_len_m1=0`, BRAM preloaded with mem[i]=i[7:0], `out_ready=1` -> exactly one word 0x10 with `out_last=1`; `busy` falls and `cmd_ready` rises afterwards. Check the first-valid cycle for latency 0 and 1.
- **Wrap-around:** `cmd_addr=0x3FE`, `cmd_len_m1=3` -> data from addresses 0x3FE, 0x3FF, 0x000, 0x001; `out_last` only on the fourth word.
- **Backpressure:** 16-word command with `out_ready` toggling in a 3-low/1-high pattern -> all 16 words delivered in order, none dropped or duplicated; `bram_address` stalls while the FIFO is full; data stays stable while stalled.
- **Throughput:** 64-word command with `out_ready=1` -> 64 consecutive valid cycles, for both `BRAM_LATENCY` values.
- **Abort:** `abort` after 5 words of a 32-word command, with the FIFO partly full -> next cycle `out_valid=0`; state IDLE; `cmd_ready=1`; a new command then streams from its own address with no stale data.
- **Async reset:** `reset_n` dropped mid-FETCH, off a clock edge -> all outputs at reset values immediately; after release, normal command operation.
